pheap_root_ctrl: RTL and testbench

- Front end and level-1 controller of the pipelined heap priority queue.
- Accepts client ENQ/DEQ/ENQ_DEQ requests over a valid/ready handshake and holds the root entry in a register.
- Returns dequeued key/value pairs to the client.
- Acts as the initiator toward the level-2 `leq` controller, driving start/op/kv/startPos into the pipeline with enforced issue spacing.

---
 rtl/pheap_root_ctrl_pkg.sv | 45 ++++
 rtl/pheap_root_ctrl_if.sv | 22 ++
 rtl/pheap_root_ctrl_child_sel.sv | 36 +++
 rtl/pheap_root_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pheap_root_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pheap_root_ctrl_pkg.sv
// Shared types and helpers for the pipelined heap priority queue root controller.
// Optional error-pulse output is enabled by defining PHEAP_ROOT_ERR_EN.
package pheap_root_ctrl_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int CAP_W = 8;

  typedef enum logic [1:0] {
    LEQ     = 2'd0,
    DEQ     = 2'd1,
    ENQ_DEQ = 2'd2
  } opcode_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef struct packed {
    logic             active;
    logic [CAP_W-1:0] capacity;
    kv_t              kv;
  } entry_t;

  localparam kv_t    KV_EMPTY    = '0;
  localparam entry_t ENTRY_EMPTY = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Number of nodes in a full heap of the given depth.
  function automatic int pheap_capacity(input int levels);
    return (1 << levels) - 1;
  endfunction

  // Enqueue goes left while the left subtree has room at least equal to the right.
  function automatic logic pick_enq_pos(input entry_t l, input entry_t r);
    return !((l.capacity != '0) && (l.capacity >= r.capacity));
  endfunction

endpackage

// File: rtl/pheap_root_ctrl_if.sv
// Client request / dequeue-response bundle for the heap root controller.
interface pheap_root_ctrl_if;
  import pheap_root_ctrl_pkg::*;

  logic    req_valid;
  logic    req_ready;
  opcode_t req_op;
  kv_t     req_kv;
  logic    deq_valid;
  kv_t     deq_kv;

  modport master (
    output req_valid, req_op, req_kv,
    input  req_ready, deq_valid, deq_kv
  );

  modport slave (
    input  req_valid, req_op, req_kv,
    output req_ready, deq_valid, deq_kv
  );

endinterface

// File: rtl/pheap_root_ctrl_child_sel.sv
// Combinational comparison of an incoming key against the two level-2 nodes.
// An inactive child behaves as smaller than any key; ties between children pick left.
module pheap_root_ctrl_child_sel
  import pheap_root_ctrl_pkg::*;
(
  input  logic [KEY_W-1:0] in_key,
  input  logic             l_active,
  input  kv_t              l_kv,
  input  logic             r_active,
  input  kv_t              r_kv,
  output logic             in_gt_both,
  output logic             max_pos,
  output kv_t              max_kv
);

  logic gt_l;
  logic gt_r;
  logic pick_l;

  // Rank the incoming key against both children and select the larger child.
  always_comb begin
    gt_l       = !l_active || (in_key > l_kv.key);
    gt_r       = !r_active || (in_key > r_kv.key);
    in_gt_both = gt_l && gt_r;
    pick_l     = l_active && (!r_active || (l_kv.key >= r_kv.key));
    max_pos    = !pick_l && r_active;
    if (pick_l) begin
      max_kv = l_kv;
    end else if (r_active) begin
      max_kv = r_kv;
    end else begin
      max_kv = KV_EMPTY;
    end
  end

endmodule

// File: rtl/pheap_root_ctrl.sv
// Level-1 controller of the pipelined heap: holds the root entry, serves client
// ENQ/DEQ/ENQ_DEQ requests and issues work to level 2 with enforced spacing.
// Define PHEAP_ROOT_ERR_EN to add an err pulse for LEQ-when-full / DEQ-when-empty.
module pheap_root_ctrl
  import pheap_root_ctrl_pkg::*;
#(
  parameter  int LEVELS    = 4,
  parameter  int ISSUE_GAP = 2,
  localparam int CAPACITY  = pheap_capacity(LEVELS),
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  pheap_root_ctrl_if.slave   client,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               l2_start,
  output opcode_t            l2_op,
  output kv_t                l2_kv,
  output logic               l2_pos,
  input  logic               l2_active,
  input  entry_t             rBotL,
  input  entry_t             rBotR
`ifdef PHEAP_ROOT_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int GAP_W = $clog2(ISSUE_GAP + 1);

  state_t           state;
  state_t           state_n;
  logic [GAP_W-1:0] gap;
  logic             accept;

  opcode_t          op_p0;
  kv_t              kv_p0;

  entry_t           root;
  entry_t           root_n;
  logic [CNT_W-1:0] count_n;
  logic             deq_fire;
  kv_t              deq_kv_n;
  logic             issue;
  kv_t              issue_kv;
  logic             issue_pos;

  logic             deq_valid_p1;
  kv_t              deq_kv_p1;

  logic             in_gt_both;
  logic             max_pos;
  kv_t              max_kv;

  assign full             = (count == CNT_W'(CAPACITY));
  assign empty            = (count == '0);
  assign client.req_ready = (state == ST_IDLE) && (gap == '0) && !l2_active;
  assign client.deq_valid = deq_valid_p1;
  assign client.deq_kv    = deq_kv_p1;
  assign accept           = client.req_valid && client.req_ready;

  pheap_root_ctrl_child_sel u_child_sel (
    .in_key     (kv_p0.key),
    .l_active   (rBotL.active),
    .l_kv       (rBotL.kv),
    .r_active   (rBotR.active),
    .r_kv       (rBotR.kv),
    .in_gt_both (in_gt_both),
    .max_pos    (max_pos),
    .max_kv     (max_kv)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state: one EXEC cycle per request, then GAP only after an issue.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_EXEC;
      ST_EXEC: state_n = issue ? ST_GAP : ST_IDLE;
      ST_GAP:  if (gap <= GAP_W'(1)) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // ---- p0: request capture ----
  // Latch the accepted request; evaluated in the following EXEC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= client.req_op;
      kv_p0 <= client.req_kv;
    end
  end

  // Evaluate the latched request against the root and the (idle, stable) level-2 nodes.
  always_comb begin
    root_n    = root;
    count_n   = count;
    deq_fire  = 1'b0;
    deq_kv_n  = KV_EMPTY;
    issue     = 1'b0;
    issue_kv  = KV_EMPTY;
    issue_pos = 1'b0;
    case (op_p0)
      LEQ: begin
        if (!full) begin
          count_n = count + 1'b1;
          if (!root.active) begin
            root_n = '{active: 1'b1, capacity: CAP_W'(CAPACITY - 1), kv: kv_p0};
          end else begin
            issue           = 1'b1;
            issue_pos       = pick_enq_pos(rBotL, rBotR);
            root_n.capacity = root.capacity - 1'b1;
            if (kv_p0.key > root.kv.key) begin
              root_n.kv = kv_p0;
              issue_kv  = root.kv;
            end else begin
              issue_kv  = kv_p0;
            end
          end
        end
      end
      DEQ: begin
        deq_fire = 1'b1;
        if (!empty) begin
          deq_kv_n        = root.kv;
          root_n.capacity = root.capacity + 1'b1;
          count_n         = count - 1'b1;
          if (!rBotL.active && !rBotR.active) begin
            root_n.active = 1'b0;
            root_n.kv     = KV_EMPTY;
          end else begin
            root_n.kv = max_kv;
            issue     = 1'b1;
            issue_pos = max_pos;
          end
        end
      end
      ENQ_DEQ: begin
        deq_fire = 1'b1;
        if (!root.active || (kv_p0.key >= root.kv.key)) begin
          deq_kv_n = kv_p0;
        end else begin
          deq_kv_n = root.kv;
          if (in_gt_both) begin
            root_n.kv = kv_p0;
          end else begin
            root_n.kv = max_kv;
            issue     = 1'b1;
            issue_kv  = kv_p0;
            issue_pos = max_pos;
          end
        end
      end
      default: ;
    endcase
  end

  // ---- p1: registered results, start pulse and issue-gap counter ----
  // Commit EXEC results; start/deq_valid are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      root         <= '{active: 1'b0, capacity: CAP_W'(CAPACITY), kv: KV_EMPTY};
      count        <= '0;
      gap          <= '0;
      deq_valid_p1 <= 1'b0;
      deq_kv_p1    <= KV_EMPTY;
      l2_start     <= 1'b0;
      l2_op        <= LEQ;
      l2_kv        <= KV_EMPTY;
      l2_pos       <= 1'b0;
    end else begin
      deq_valid_p1 <= 1'b0;
      l2_start     <= 1'b0;
      if (state == ST_EXEC) begin
        root         <= root_n;
        count        <= count_n;
        deq_valid_p1 <= deq_fire;
        if (deq_fire) deq_kv_p1 <= deq_kv_n;
        l2_start     <= issue;
        if (issue) begin
          l2_op  <= op_p0;
          l2_kv  <= issue_kv;
          l2_pos <= issue_pos;
        end
        gap <= issue ? GAP_W'(ISSUE_GAP) : '0;
      end else if (state == ST_GAP) begin
        gap <= gap - 1'b1;
      end
    end
  end

`ifdef PHEAP_ROOT_ERR_EN
  logic err_n;
  assign err_n = ((op_p0 == LEQ) && full) || ((op_p0 == DEQ) && empty);

  // Error pulse aligned with the request's result cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (state == ST_EXEC) && err_n;
    end
  end
`endif

endmodule

// File: tb/tb_pheap_root_ctrl.sv
// Randomized self-checking bench for pheap_root_ctrl against a transaction-level model.
module tb_pheap_root_ctrl;
  import pheap_root_ctrl_pkg::*;

  localparam int CAP = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pheap_root_ctrl_if cif ();

  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       l2_start;
  opcode_t    l2_op;
  kv_t        l2_kv;
  logic       l2_pos;
  logic       l2_active;
  entry_t     bot_l;
  entry_t     bot_r;
`ifdef PHEAP_ROOT_ERR_EN
  logic       err;
`endif

  pheap_root_ctrl #(.LEVELS(4), .ISSUE_GAP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .client    (cif.slave),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .l2_start  (l2_start),
    .l2_op     (l2_op),
    .l2_kv     (l2_kv),
    .l2_pos    (l2_pos),
    .l2_active (l2_active),
    .rBotL     (bot_l),
    .rBotR     (bot_r)
`ifdef PHEAP_ROOT_ERR_EN
    ,
    .err       (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the queue front looks like from outside.
  logic m_act;
  int   m_count;
  kv_t  m_kv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic kv_t mk(input int key);
    kv_t k;
    k.key = 8'(key);
    k.val = 8'(key) ^ 8'h5A;
    return k;
  endfunction

  function automatic entry_t ent(input logic act, input int cap, input int key);
    entry_t e;
    e.active   = act;
    e.capacity = 8'(cap);
    e.kv       = act ? mk(key) : KV_EMPTY;
    return e;
  endfunction

  // Child rank: inactive ranks below every key.
  function automatic int score(input entry_t e);
    return e.active ? int'(e.kv.key) : -1;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (cif.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_wait", 32'(cif.req_ready), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_deq_valid"}, 32'(cif.deq_valid), 32'd0);
    check_val({tag, "_deq_kv"}, {16'd0, cif.deq_kv}, 32'd0);
    check_val({tag, "_l2_start"}, 32'(l2_start), 32'd0);
    check_val({tag, "_l2_op"}, {30'd0, l2_op}, {30'd0, LEQ});
    check_val({tag, "_l2_kv"}, {16'd0, l2_kv}, 32'd0);
    check_val({tag, "_l2_pos"}, 32'(l2_pos), 32'd0);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_ready"}, 32'(cif.req_ready), 32'd1);
`ifdef PHEAP_ROOT_ERR_EN
    check_val({tag, "_err"}, 32'(err), 32'd0);
`endif
  endtask

  // Drive one request and wait for its acceptance edge.
  task automatic send(input opcode_t op, input kv_t kv, input entry_t l, input entry_t r);
    bot_l = l;
    bot_r = r;
    wait_ready();
    cif.req_valid = 1'b1;
    cif.req_op    = op;
    cif.req_kv    = kv;
    @(posedge clk);
    #1 cif.req_valid = 1'b0;
  endtask

  task automatic do_req(input opcode_t op, input kv_t kv, input entry_t l, input entry_t r);
    logic    e_deq, e_iss, e_pos, e_err;
    kv_t     e_dkv, e_ikv;
    int      sl, sr;
    send(op, kv, l, r);
    sl    = score(l);
    sr    = score(r);
    e_deq = 1'b0; e_dkv = KV_EMPTY; e_iss = 1'b0; e_ikv = KV_EMPTY; e_pos = 1'b0; e_err = 1'b0;
    case (op)
      LEQ: begin
        if (m_count == CAP) begin
          e_err = 1'b1;
        end else begin
          m_count++;
          if (!m_act) begin
            m_act = 1'b1;
            m_kv  = kv;
          end else begin
            e_iss = 1'b1;
            e_pos = (l.capacity != 0 && l.capacity >= r.capacity) ? 1'b0 : 1'b1;
            if (kv.key > m_kv.key) begin
              e_ikv = m_kv;
              m_kv  = kv;
            end else begin
              e_ikv = kv;
            end
          end
        end
      end
      DEQ: begin
        e_deq = 1'b1;
        if (m_count == 0) begin
          e_err = 1'b1;
        end else begin
          e_dkv = m_kv;
          m_count--;
          if (sl < 0 && sr < 0) begin
            m_act = 1'b0;
            m_kv  = KV_EMPTY;
          end else begin
            e_iss = 1'b1;
            e_pos = (sr > sl);
            m_kv  = (sr > sl) ? r.kv : l.kv;
          end
        end
      end
      default: begin
        e_deq = 1'b1;
        if (!m_act || kv.key >= m_kv.key) begin
          e_dkv = kv;
        end else begin
          e_dkv = m_kv;
          if (int'(kv.key) > sl && int'(kv.key) > sr) begin
            m_kv = kv;
          end else begin
            e_iss = 1'b1;
            e_ikv = kv;
            e_pos = (sr > sl);
            m_kv  = (sr > sl) ? r.kv : l.kv;
          end
        end
      end
    endcase

    @(negedge clk);
    check_val("exec_ready", 32'(cif.req_ready), 32'd0);
    check_val("exec_deq_valid", 32'(cif.deq_valid), 32'd0);
    check_val("exec_l2_start", 32'(l2_start), 32'd0);

    @(negedge clk);
    check_val("deq_valid", 32'(cif.deq_valid), 32'(e_deq));
    if (e_deq) check_val("deq_kv", {16'd0, cif.deq_kv}, {16'd0, e_dkv});
    check_val("l2_start", 32'(l2_start), 32'(e_iss));
    if (e_iss) begin
      check_val("l2_op", {30'd0, l2_op}, {30'd0, op});
      check_val("l2_pos", 32'(l2_pos), 32'(e_pos));
      if (op != DEQ) check_val("l2_kv", {16'd0, l2_kv}, {16'd0, e_ikv});
    end
    check_val("count", 32'(count), 32'(m_count));
    check_val("full", 32'(full), 32'(m_count == CAP));
    check_val("empty", 32'(empty), 32'(m_count == 0));
`ifdef PHEAP_ROOT_ERR_EN
    check_val("err", 32'(err), 32'(e_err));
`endif
    if (e_iss) begin
      check_val("gap_ready0", 32'(cif.req_ready), 32'd0);
      @(negedge clk);
      check_val("gap_ready1", 32'(cif.req_ready), 32'd0);
      check_val("start_pulse", 32'(l2_start), 32'd0);
      check_val("deq_pulse", 32'(cif.deq_valid), 32'd0);
      @(negedge clk);
      check_val("gap_ready2", 32'(cif.req_ready), 32'd1);
    end else begin
      check_val("ready_back", 32'(cif.req_ready), 32'd1);
    end
  endtask

  // Reset in the start cycle (extra=0) or one cycle into GAP (extra=1).
  task automatic reset_mid(input int extra, input string tag);
    do_req(LEQ, mk(5), ent(0, 7, 0), ent(0, 7, 0));
    send(LEQ, mk(9), ent(0, 7, 0), ent(0, 7, 0));
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_start_seen"}, 32'(l2_start), 32'd1);
    for (int i = 0; i < extra; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_act = 1'b0; m_count = 0; m_kv = KV_EMPTY;
    @(negedge clk);
    check_reset(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.req_valid = 1'b0;
    cif.req_op    = LEQ;
    cif.req_kv    = KV_EMPTY;
    l2_active     = 1'b0;
    bot_l         = ENTRY_EMPTY;
    bot_r         = ENTRY_EMPTY;
    m_act = 1'b0; m_count = 0; m_kv = KV_EMPTY;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("por");

    // Directed scenarios.
    do_req(LEQ, mk(5), ent(0, 7, 0), ent(0, 7, 0));
    do_req(LEQ, mk(9), ent(0, 7, 0), ent(0, 7, 0));
    do_req(DEQ, KV_EMPTY, ent(1, 3, 5), ent(1, 3, 7));
    do_req(LEQ, mk(9), ent(0, 7, 0), ent(0, 7, 0));
    do_req(ENQ_DEQ, mk(6), ent(1, 3, 5), ent(1, 3, 7));
    do_req(ENQ_DEQ, mk(12), ent(1, 3, 5), ent(1, 3, 7));

    // Level 2 busy holds off new requests.
    l2_active = 1'b1;
    @(negedge clk);
    check_val("busy_ready0", 32'(cif.req_ready), 32'd0);
    @(negedge clk);
    check_val("busy_ready1", 32'(cif.req_ready), 32'd0);
    l2_active = 1'b0;
    #1 check_val("busy_release", 32'(cif.req_ready), 32'd1);

    // Fill to capacity, overflow, drain, underflow.
    for (int i = 0; i < 40 && m_count < CAP; i++)
      do_req(LEQ, mk($urandom_range(0, 255)), ent(0, $urandom_range(0, 7), 0),
             ent(0, $urandom_range(0, 7), 0));
    do_req(LEQ, mk(200), ent(0, 1, 0), ent(0, 0, 0));
    for (int i = 0; i < 40 && m_count > 0; i++)
      do_req(DEQ, KV_EMPTY, ent(1'($urandom_range(0, 1)), 3, $urandom_range(0, 20)),
             ent(1'($urandom_range(0, 1)), 3, $urandom_range(0, 20)));
    do_req(DEQ, KV_EMPTY, ent(1, 3, 4), ent(1, 3, 6));

    // Randomized mix with small key range to exercise ties.
    for (int i = 0; i < 120; i++)
      do_req(opcode_t'($urandom_range(0, 2)), mk($urandom_range(0, 15)),
             ent(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15)),
             ent(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15)));

    // Reset while issuing and while spacing.
    reset_mid(0, "rst_start");
    reset_mid(1, "rst_gap");
    do_req(LEQ, mk(3), ent(0, 7, 0), ent(0, 7, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
